// File: rtl/pe_array_sequencer_if.sv
// Host <-> sequencer bundle for pe_array_sequencer.
// Optional macro SEQ_MASK_EN adds the pe_mask field (per-PE enable mask).
interface pe_array_sequencer_if #(
  parameter int LENGTH = 32
);
  logic              start;
  logic [31:0]       instruction;
`ifdef SEQ_MASK_EN
  logic [LENGTH-1:0] pe_mask;
`endif
  logic              busy;
  logic              done;
  logic              err;
  logic [LENGTH-1:0] pe_en;
  logic [5:0]        pe_opcode;
  logic [4:0]        pe_rs;
  logic [4:0]        pe_rt;
  logic [4:0]        pe_rd;
  logic              pe_we;

`ifdef SEQ_MASK_EN
  modport master (
    output start, instruction, pe_mask,
    input  busy, done, err, pe_en, pe_opcode, pe_rs, pe_rt, pe_rd, pe_we
  );
  modport slave (
    input  start, instruction, pe_mask,
    output busy, done, err, pe_en, pe_opcode, pe_rs, pe_rt, pe_rd, pe_we
  );
`else
  modport master (
    output start, instruction,
    input  busy, done, err, pe_en, pe_opcode, pe_rs, pe_rt, pe_rd, pe_we
  );
  modport slave (
    input  start, instruction,
    output busy, done, err, pe_en, pe_opcode, pe_rs, pe_rt, pe_rd, pe_we
  );
`endif
endinterface

// File: rtl/pe_array_sequencer.sv
// Issue controller: accepts one instruction per start edge, decodes it and
// broadcasts it to the PE array GROUP PEs per beat, stretching beats for
// multiply-class opcodes. Optional macro SEQ_MASK_EN adds a per-PE mask that
// gates pe_en and skips groups whose mask slice is empty.
module pe_array_sequencer #(
  parameter int SIZE    = 5,
  parameter int LENGTH  = 32,
  parameter int GROUP   = 8,
  parameter int MUL_LAT = 3
) (
  input logic                  clk,
  input logic                  reset,
  pe_array_sequencer_if.slave  bus
);

  localparam int NGRP = LENGTH / GROUP;
  localparam int BW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int CW   = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [CW-1:0]     len_q, len_d;
  logic              err_q, err_d;
  logic [5:0]        op_q, op_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        rd_q, rd_d;
  logic [LENGTH-1:0] mask_q, mask_d;

  logic [NGRP-1:0]   grp_vld;
  logic [BW:0]       nxt_grp;
  int                search_from;
  logic              accept;
  logic              last_cyc;
  logic [SIZE-1:0]   base_addr;
  logic [LENGTH-1:0] grp_ones;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^bus.instruction[10:0];

  // Lowest group index >= from whose valid bit is set; MSB flags a hit.
  function automatic logic [BW:0] find_grp(input logic [NGRP-1:0] vld, input int from);
    logic [BW:0] res;
    res = '0;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (vld[g] && (g >= from)) res = {1'b1, BW'(g)};
    end
    return res;
  endfunction

  // Which groups take part in the issue sequence.
  always_comb begin
    grp_vld = '1;
`ifdef SEQ_MASK_EN
    for (int g = 0; g < NGRP; g++) grp_vld[g] = |mask_q[g*GROUP +: GROUP];
`endif
  end

  assign accept      = (state_q == S_IDLE) && bus.start && !start_q;
  assign last_cyc    = (cyc_q == len_q - CW'(1));
  assign search_from = (state_q == S_ISSUE) ? int'(beat_q) + 1 : 0;
  assign nxt_grp     = find_grp(grp_vld, search_from);

  // Next-state logic: edge detect, decode, beat/cycle sequencing.
  always_comb begin
    state_d = state_q;
    start_d = bus.start;
    beat_d  = beat_q;
    cyc_d   = cyc_q;
    len_d   = len_q;
    err_d   = err_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = bus.instruction[31:26];
          rs_d    = bus.instruction[25:21];
          rt_d    = bus.instruction[20:16];
          rd_d    = bus.instruction[15:11];
          err_d   = 1'b0;
`ifdef SEQ_MASK_EN
          mask_d  = bus.pe_mask;
`else
          mask_d  = '1;
`endif
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        beat_d = '0;
        cyc_d  = '0;
        if (op_q == 6'h00) begin
          state_d = S_DONE;
        end else if (op_q[5:4] != 2'b00) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          len_d = op_q[3] ? CW'(MUL_LAT) : CW'(1);
          // An empty mask leaves nothing to issue.
          if (nxt_grp[BW]) begin
            beat_d  = nxt_grp[BW-1:0];
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (last_cyc) begin
          cyc_d = '0;
          if (nxt_grp[BW]) begin
            beat_d = nxt_grp[BW-1:0];
          end else begin
            beat_d  = '0;
            state_d = S_DONE;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        beat_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any beat in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      beat_q  <= '0;
      cyc_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      beat_q  <= beat_d;
      cyc_q   <= cyc_d;
      len_q   <= len_d;
      err_q   <= err_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      mask_q  <= mask_d;
    end
  end

  // First PE address of the current beat selects the enabled window.
  assign base_addr = SIZE'(int'(beat_q) * GROUP);
  assign grp_ones  = LENGTH'({GROUP{1'b1}});

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
  assign bus.pe_en     = (state_q == S_ISSUE) ? ((grp_ones << base_addr) & mask_q) : '0;
  assign bus.pe_we     = (state_q == S_ISSUE) && last_cyc;
  assign bus.pe_opcode = op_q;
  assign bus.pe_rs     = rs_q;
  assign bus.pe_rt     = rt_q;
  assign bus.pe_rd     = rd_q;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Self-checking bench for pe_array_sequencer (LENGTH=32, GROUP=8, MUL_LAT=3).
// Build with +define+SEQ_MASK_EN to also exercise the pe_mask path.
module tb_pe_array_sequencer;
  localparam int LENGTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pe_array_sequencer_if #(.LENGTH(LENGTH)) bus();

  pe_array_sequencer #(
    .SIZE(5), .LENGTH(LENGTH), .GROUP(8), .MUL_LAT(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // len: cycles per beat (0 = no issue); done_k: cycles after the accept edge
  typedef struct {
    logic [31:0] instr;
    int          len;
    int          done_k;
    logic        exp_err;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] en_exp;
    logic        we_exp;
    int          done_at;
    done_at = -1;
    bus.instruction = v.instr;
    bus.start = 1'b1;
    for (int k = 1; k <= v.done_k + 1; k++) begin
      tick;
      if (k == 1) bus.instruction = ~v.instr;
      en_exp = '0;
      we_exp = 1'b0;
      if (v.len > 0 && k >= 2 && k < 2 + 4 * v.len) begin
        en_exp = 32'hFF << (8 * ((k - 2) / v.len));
        we_exp = (((k - 2) % v.len) == v.len - 1);
      end
      check($sformatf("v%0d_k%0d_pe_en", idx, k), bus.pe_en, en_exp);
      check($sformatf("v%0d_k%0d_pe_we", idx, k), bus.pe_we, we_exp);
      check($sformatf("v%0d_k%0d_busy", idx, k), bus.busy, k <= v.done_k);
      check($sformatf("v%0d_k%0d_done", idx, k), bus.done, k == v.done_k);
      check($sformatf("v%0d_k%0d_err", idx, k), bus.err, (k >= 2) ? v.exp_err : 1'b0);
      if (k == 1 || k == v.done_k) begin
        check($sformatf("v%0d_k%0d_opcode", idx, k), bus.pe_opcode, v.op);
        check($sformatf("v%0d_k%0d_rs", idx, k), bus.pe_rs, v.rs);
        check($sformatf("v%0d_k%0d_rt", idx, k), bus.pe_rt, v.rt);
        check($sformatf("v%0d_k%0d_rd", idx, k), bus.pe_rd, v.rd);
      end
      if (bus.done && done_at < 0) done_at = k;
    end
    check($sformatf("v%0d_done_cycle", idx), done_at, v.done_k);
    bus.start = 1'b0;
    tick;
  endtask

  initial begin
    int dn;
    int we;
    int first_done;

    vecs[0] = '{32'h1C241800, 1, 6, 1'b0, 6'h07, 5'd1, 5'd4, 5'd3};
    vecs[1] = '{32'h20000000, 3, 14, 1'b0, 6'h08, 5'd0, 5'd0, 5'd0};
    vecs[2] = '{32'hFC000000, 0, 2, 1'b1, 6'h3F, 5'd0, 5'd0, 5'd0};
    vecs[3] = '{32'h00000000, 0, 2, 1'b0, 6'h00, 5'd0, 5'd0, 5'd0};
    vecs[4] = '{32'h40000000, 0, 2, 1'b1, 6'h10, 5'd0, 5'd0, 5'd0};
    vecs[5] = '{32'h04000000, 1, 6, 1'b0, 6'h01, 5'd0, 5'd0, 5'd0};
    vecs[6] = '{32'h2C63FFFF, 3, 14, 1'b0, 6'h0B, 5'd3, 5'd3, 5'd31};
    vecs[7] = '{32'h3C000000, 3, 14, 1'b0, 6'h0F, 5'd0, 5'd0, 5'd0};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.instruction = 32'h1C241800;
`ifdef SEQ_MASK_EN
    bus.pe_mask = '1;
`endif
    repeat (10) tick;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_pe_en", bus.pe_en, 32'h0);
    check("rst_pe_we", bus.pe_we, 1'b0);
    check("rst_opcode", bus.pe_opcode, 6'h0);
    check("rst_rs", bus.pe_rs, 5'h0);
    check("rst_rt", bus.pe_rt, 5'h0);
    check("rst_rd", bus.pe_rd, 5'h0);
    reset = 1'b0;
    tick;
    check("idle_busy", bus.busy, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Start held high for 1000 cycles issues exactly once.
    dn = 0;
    we = 0;
    bus.instruction = 32'h1C241800;
    bus.start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      tick;
      if (bus.done) dn++;
      if (bus.pe_we) we++;
    end
    check("held_done_count", dn, 1);
    check("held_we_count", we, 4);
    bus.start = 1'b0;
    tick;
    bus.start = 1'b1;
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (bus.done) dn++;
    end
    check("reissue_done_count", dn, 1);
    bus.start = 1'b0;
    tick;

    // Reset during beat 2 of a MUL instruction.
    bus.instruction = 32'h20000000;
    bus.start = 1'b1;
    repeat (8) tick;
    check("mid_beat2_pe_en", bus.pe_en, 32'h00FF0000);
    reset = 1'b1;
    tick;
    check("midrst_pe_en", bus.pe_en, 32'h0);
    check("midrst_pe_we", bus.pe_we, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_opcode", bus.pe_opcode, 6'h0);
    tick;
    check("midrst_hold_done", bus.done, 1'b0);
    // start still high through release: accepted on the first cycle out of reset
    reset = 1'b0;
    tick;
    check("rel_busy", bus.busy, 1'b1);
    first_done = -1;
    for (int k = 2; k <= 30; k++) begin
      tick;
      if (bus.done && first_done < 0) first_done = k;
    end
    check("rel_done_cycle", first_done, 14);
    bus.start = 1'b0;
    tick;

`ifdef SEQ_MASK_EN
    bus.pe_mask = 32'h00FF0001;
    bus.instruction = 32'h1C241800;
    bus.start = 1'b1;
    tick;
    check("mask_k1_busy", bus.busy, 1'b1);
    tick;
    check("mask_k2_pe_en", bus.pe_en, 32'h00000001);
    check("mask_k2_pe_we", bus.pe_we, 1'b1);
    tick;
    check("mask_k3_pe_en", bus.pe_en, 32'h00FF0000);
    tick;
    check("mask_k4_done", bus.done, 1'b1);
    check("mask_k4_pe_en", bus.pe_en, 32'h0);
    bus.start = 1'b0;
    tick;
    bus.pe_mask = 32'h0;
    bus.start = 1'b1;
    tick;
    check("mask0_k1_busy", bus.busy, 1'b1);
    tick;
    check("mask0_k2_done", bus.done, 1'b1);
    check("mask0_k2_err", bus.err, 1'b0);
    check("mask0_k2_pe_en", bus.pe_en, 32'h0);
    bus.start = 1'b0;
    bus.pe_mask = '1;
    tick;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pe_array_sequencer.md
Name: pe_array_sequencer

Overview:
- Issue controller between the host instruction interface and the PE array.
- Accepts one 32-bit instruction per start edge, decodes it, and broadcasts it to the LENGTH PEs in groups of GROUP PEs per beat.
- Stretches each beat for multi-cycle opcodes, flags illegal opcodes, and reports busy/done to the host.

Parameters:
- SIZE, 5: PE address width; LENGTH must not exceed 2**SIZE.
- LENGTH, 32: number of PEs; must be divisible by GROUP.
- GROUP, 8: PEs enabled per issue beat.
- MUL_LAT, 3: cycles per beat for multiply-class opcodes; must be at least 1.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; a 0->1 transition sampled in IDLE launches an instruction.
- instruction  in  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:0] ignored.
- busy  out  1  high from DECODE through DONE inclusive.
- done  out  1  one-cycle pulse at completion (legal or illegal).
- err  out  1  sticky illegal-opcode flag; cleared at the next accepted start.
- pe_en  out  LENGTH  PE enable, one-hot per group.
- pe_opcode  out  6  latched opcode broadcast.
- pe_rs  out  5  latched rs broadcast.
- pe_rt  out  5  latched rt broadcast.
- pe_rd  out  5  latched rd broadcast.
- pe_we  out  1  PE register write strobe.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, beat/cycle counters 0, start_q 0.
  - Reset has priority over all other events, including mid-issue: the current beat is abandoned with no pe_we.
  - A start held high through reset release counts as an edge on the first cycle out of reset.
- Edge detect: start_q <= start every cycle. Accept only when state==IDLE && start && !start_q. A start held high across completion does not re-trigger.
- IDLE -> DECODE on accept.
  - Latch instruction fields into the pe_* registers.
  - Clear err.
- DECODE (1 cycle), classify opcode:
  - 0x00 NOP: go to DONE.
  - 0x01-0x07 ALU: go to ISSUE with beat length 1.
  - 0x08-0x0F MUL: go to ISSUE with beat length MUL_LAT.
  - 0x10-0x3F illegal: set err, go to DONE.
- ISSUE, for beat b = 0 .. LENGTH/GROUP-1:
  - pe_en[b*GROUP +: GROUP] = all ones; all other bits 0.
  - Held for the beat length.
  - pe_we = 1 only on the last cycle of each beat.
  - The beat counter advances after the last cycle. After the final beat, go to DONE.
- DONE (1 cycle): done=1, busy=1, pe_en=0, then IDLE.
- Latency, measured from the accept edge at cycle T (T+1 = DECODE):
  - ALU: pe_en active T+2 .. T+1+LENGTH/GROUP; done at T+2+LENGTH/GROUP.
  - MUL: issue window is LENGTH/GROUP*MUL_LAT cycles.
- pe_opcode/rs/rt/rd are stable from DECODE until the next accept. Changes on instruction while busy are ignored.
- start edges while busy are ignored and not queued.
- Counter widths: beat counter ceil(log2(LENGTH/GROUP)) bits min 1; cycle counter ceil(log2(MUL_LAT+1)) bits. Beat counter wraps to 0 on DONE.

Optional Feature:
- Macro: SEQ_MASK_EN.
- Defined:
  - Adds input pe_mask[LENGTH-1:0], latched on accept.
  - pe_en = group ones AND latched mask.
  - Groups whose mask slice is all zero are skipped entirely (no cycles spent).
  - All-zero mask: DECODE goes directly to DONE; err unaffected.
- Undefined: no pe_mask port; all groups always issued.

Test Plan:
- Reset held 10 cycles with start=0 -> all outputs 0. Release reset, start 0->1 with instruction=0x1C241800 (opcode 7, rs 1, rt 4, rd 3) -> busy T+1.
  - pe_en = 0x000000FF, 0x0000FF00, 0x00FF0000, 0xFF000000 on T+2..T+5.
  - pe_we=1 each of those cycles; pe_opcode=7, pe_rs=1, pe_rt=4, pe_rd=3.
  - done pulse at T+6; busy low at T+7.
- MUL opcode 0x08 (instruction=0x20000000) -> each pe_en group held 3 cycles, pe_we only on the 3rd; 12 issue cycles; done at T+14.
- Illegal opcode 0x3F -> err=1 and done at T+2, pe_en never nonzero. A following legal start -> err cleared at accept.
- start held high for 1000 cycles -> exactly one instruction issued. start low then high again -> second issue.
- Reset asserted during beat 2 of a MUL instruction -> next cycle pe_en=0, pe_we=0, busy=0, no done pulse.
- With SEQ_MASK_EN, pe_mask=0x00FF0001 -> only beats 0 and 2 issued (pe_en=0x00000001, then 0x00FF0000); done at T+4.
